// File: rtl/lutnet_pkg.sv
// Shared sizing, state encoding and config-select constants for the LUT layer scheduler.
package lutnet_pkg;

  localparam int IN_BITS   = 64;
  localparam int N_NEURONS = 16;
  localparam int FANIN     = 8;
  localparam int IBW       = $clog2(IN_BITS);
  // One spare code beyond IN_BITS-1 so that an out-of-range index can be presented and rejected.
  localparam int IDXW      = $clog2(IN_BITS + 1);
  localparam int NW        = $clog2(N_NEURONS);
  localparam int KW        = $clog2(FANIN);
  localparam int CFG_AW    = NW + FANIN;

  localparam logic CFG_SEL_TT   = 1'b0;
  localparam logic CFG_SEL_CONN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic conn_in_range(input logic [IDXW-1:0] idx);
    return idx < IDXW'(IN_BITS);
  endfunction

endpackage

// File: rtl/lut_layer_sched_if.sv
// Data-side valid/ready handshakes, config port and status of the LUT layer scheduler.
interface lut_layer_sched_if;
  import lutnet_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_vec;
  logic                out_valid;
  logic                out_ready;
  logic [N_NEURONS-1:0] out_vec;
  logic                cfg_we;
  logic                cfg_sel;
  logic [CFG_AW-1:0]   cfg_addr;
  logic [IDXW-1:0]     cfg_wdata;
  logic                cfg_err;
  logic                busy;

  modport master (
    output in_valid, in_vec, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    input  in_ready, out_valid, out_vec, cfg_err, busy
  );

  modport slave (
    input  in_valid, in_vec, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    output in_ready, out_valid, out_vec, cfg_err, busy
  );

endinterface

// File: rtl/lut_layer_mem.sv
// Truth-table and connectivity storage: one synchronous write port each, combinational reads.
module lut_layer_mem
  import lutnet_pkg::*;
(
  input  logic                        clk,
  input  logic                        tt_we,
  input  logic [CFG_AW-1:0]           tt_waddr,
  input  logic                        tt_wdata,
  input  logic                        conn_we,
  input  logic [NW+KW-1:0]            conn_waddr,
  input  logic [IDXW-1:0]             conn_wdata,
  input  logic [NW-1:0]               conn_rn,
  output logic [FANIN-1:0][IDXW-1:0]  conn_row,
  input  logic [CFG_AW-1:0]           tt_raddr,
  output logic                        tt_rdata
);

  logic            tt_mem   [N_NEURONS*(2**FANIN)];
  logic [IDXW-1:0] conn_mem [N_NEURONS*FANIN];

  // Table writes; contents are deliberately left out of reset so they survive rst.
  always_ff @(posedge clk) begin
    if (tt_we) begin
      tt_mem[tt_waddr] <= tt_wdata;
    end
    if (conn_we) begin
      conn_mem[conn_waddr] <= conn_wdata;
    end
  end

  // Whole connectivity row of one neuron, entry k at {neuron, k}.
  always_comb begin
    conn_row = '0;
    for (int k = 0; k < FANIN; k++) begin
      conn_row[k] = conn_mem[{conn_rn, k[KW-1:0]}];
    end
  end

  assign tt_rdata = tt_mem[tt_raddr];

endmodule

// File: rtl/lut_layer_sched.sv
// Time-multiplexed LogicNets layer: one neuron per cycle through gather -> address register -> LUT read.
module lut_layer_sched
  import lutnet_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  lut_layer_sched_if.slave  bus
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] DONE  = ST_DONE;
  localparam logic [NW-1:0] LAST_N = NW'(N_NEURONS - 1);

  logic [1:0]                 state_r;
  logic [1:0]                 state_nx_s;
  logic [NW-1:0]              n_r;
  logic                       drain_r;
  logic [IN_BITS-1:0]         in_reg_r;
  logic [FANIN-1:0]           addr_s;
  logic [FANIN-1:0]           addr_r;
  logic [NW-1:0]              n_s2_r;
  logic                       s2_valid_r;
  logic [N_NEURONS-1:0]       out_vec_r;
  logic                       out_valid_r;
  logic                       in_ready_r;
  logic                       busy_r;
  logic                       cfg_err_r;
  logic                       accept_s;
  logic                       cfg_ok_s;
  logic                       tt_we_s;
  logic                       conn_we_s;
  logic [FANIN-1:0][IDXW-1:0] conn_row_s;
  logic                       tt_rdata_s;

  lut_layer_mem u_mem (
    .clk        (clk),
    .tt_we      (tt_we_s),
    .tt_waddr   (bus.cfg_addr),
    .tt_wdata   (bus.cfg_wdata[0]),
    .conn_we    (conn_we_s),
    .conn_waddr (bus.cfg_addr[NW+KW-1:0]),
    .conn_wdata (bus.cfg_wdata),
    .conn_rn    (n_r),
    .conn_row   (conn_row_s),
    .tt_raddr   ({n_s2_r, addr_r}),
    .tt_rdata   (tt_rdata_s)
  );

  assign accept_s = (state_r == IDLE) && bus.in_valid;

  // Config write qualification: IDLE only, and connectivity indices must address a real input bit.
  always_comb begin
    cfg_ok_s  = 1'b0;
    tt_we_s   = 1'b0;
    conn_we_s = 1'b0;
    if (bus.cfg_we && (state_r == IDLE)) begin
      if (bus.cfg_sel == CFG_SEL_CONN) begin
        cfg_ok_s  = conn_in_range(bus.cfg_wdata);
        conn_we_s = cfg_ok_s;
      end else begin
        cfg_ok_s = 1'b1;
        tt_we_s  = 1'b1;
      end
    end else begin
      cfg_ok_s = 1'b0;
    end
  end

  // Gather: LUT address bit k is the input bit named by connectivity entry k of the issuing neuron.
  always_comb begin
    addr_s = '0;
    for (int k = 0; k < FANIN; k++) begin
      if (conn_in_range(conn_row_s[k])) begin
        addr_s[k] = in_reg_r[conn_row_s[k][IBW-1:0]];
      end else begin
        addr_s[k] = 1'b0;
      end
    end
  end

  // Next-state logic of the scheduler.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_nx_s = RUN;
        else              state_nx_s = IDLE;
      end
      RUN: begin
        if (n_r == LAST_N) state_nx_s = DRAIN;
        else               state_nx_s = RUN;
      end
      DRAIN: begin
        if (drain_r) state_nx_s = DONE;
        else         state_nx_s = DRAIN;
      end
      DONE: begin
        if (bus.out_ready) state_nx_s = IDLE;
        else               state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, counters, pipeline and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      n_r         <= '0;
      drain_r     <= 1'b0;
      in_reg_r    <= '0;
      addr_r      <= '0;
      n_s2_r      <= '0;
      s2_valid_r  <= 1'b0;
      out_vec_r   <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == IDLE);
      busy_r      <= (state_nx_s == RUN) || (state_nx_s == DRAIN);
      out_valid_r <= (state_nx_s == DONE);
      cfg_err_r   <= bus.cfg_we && !cfg_ok_s;

      if (accept_s) begin
        in_reg_r <= bus.in_vec;
        n_r      <= '0;
      end else if ((state_r == RUN) && (n_r != LAST_N)) begin
        n_r <= n_r + NW'(1);
      end else begin
        n_r <= n_r;
      end

      if (state_r == DRAIN) drain_r <= ~drain_r;
      else                  drain_r <= 1'b0;

      s2_valid_r <= (state_r == RUN);
      n_s2_r     <= n_r;
      addr_r     <= addr_s;

      if (accept_s) begin
        out_vec_r <= '0;
      end else if (s2_valid_r) begin
        out_vec_r[n_s2_r] <= tt_rdata_s;
      end else begin
        out_vec_r <= out_vec_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_vec   = out_vec_r;
  assign bus.cfg_err   = cfg_err_r;
  assign bus.busy      = busy_r;

endmodule
